// File: rtl/matmul_mode_ctrl.sv
// matmul_mode_ctrl: NORMAL/MATMUL2 mode controller sitting between decode and fetch.
// Detects STARTMATMUL2 / ENDMATMUL in decode. On each mode change it saves or restores
// the return PC, switches the instruction-memory select, and issues a one-cycle PC
// redirect together with an F/D flush.
//
// Optional feature macro: MATMUL_CYCLE_CNT_EN (enables the MATMUL2 residency counter).
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous, active-low reset
//   instr_d      in   [31:0] instruction in decode
//   pc_d         in   [31:0] PC of instr_d
//   valid_d      in   instr_d is a real (non-bubble) instruction
//   stall_d      in   decode held this cycle; no detection while high
//   redirect     out  one-cycle pulse; fetch loads redirect_pc
//   redirect_pc  out  [31:0] redirect target (0 when not redirecting)
//   flush_fd     out  squash F/D register, asserted with redirect
//   im_sel       out  0 = program imem, 1 = MATMUL2 microcode imem
//   fsm_state    out  architectural mode, 0 = NORMAL, 1 = MATMUL2
//   pc_backup    out  [31:0] saved return PC
//   busy         out  high in ENTER and EXIT
//   err          out  sticky protocol error
//   mm_cycles    out  [CNT_W-1:0] MATMUL2 residency count (0 when feature disabled)

module matmul_mode_ctrl #(
    parameter logic [31:0] UCODE_BASE = 32'h0000_0000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_d,
    input  logic [31:0]      pc_d,
    input  logic             valid_d,
    input  logic             stall_d,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             flush_fd,
    output logic             im_sel,
    output logic             fsm_state,
    output logic [31:0]      pc_backup,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] mm_cycles
);

    localparam logic [6:0] OPC_MATMUL   = 7'b1111010;
    localparam logic [2:0] FUNCT3_START = 3'b000;
    localparam logic [2:0] FUNCT3_END   = 3'b111;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_ENTER   = 2'd1,
        ST_MATMUL2 = 2'd2,
        ST_EXIT    = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_backup_d;
    logic        err_d;
    logic        redirect_d;
    logic [31:0] redirect_pc_d;
    logic        in_mm_d;
    logic        dec_ok;
    logic        start_det;
    logic        end_det;

    // Only opcode and funct3 take part in decoding.
    logic unused_instr;
    assign unused_instr = ^{instr_d[31:15], instr_d[11:7]};

    // Instruction detection, qualified by a live, unstalled decode slot.
    always_comb begin
        dec_ok    = valid_d & ~stall_d;
        start_det = dec_ok && (instr_d[6:0] == OPC_MATMUL) && (instr_d[14:12] == FUNCT3_START);
        end_det   = dec_ok && (instr_d[6:0] == OPC_MATMUL) && (instr_d[14:12] == FUNCT3_END);
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_d       = state_q;
        pc_backup_d   = pc_backup;
        err_d         = err;
        redirect_d    = 1'b0;
        redirect_pc_d = 32'h0;
        in_mm_d       = 1'b0;

        unique case (state_q)
            ST_NORMAL: begin
                if (start_det) begin
                    state_d     = ST_ENTER;
                    pc_backup_d = pc_d + 32'd4;
                end else if (end_det) begin
                    err_d = 1'b1;
                end
            end
            // Decode slot is being flushed here, so its contents are ignored.
            ST_ENTER: state_d = ST_MATMUL2;
            ST_MATMUL2: begin
                if (end_det) begin
                    state_d = ST_EXIT;
                end else if (start_det) begin
                    err_d = 1'b1;
                end
            end
            ST_EXIT: state_d = ST_NORMAL;
            default: state_d = ST_NORMAL;
        endcase

        // Outputs are registered against the next state so they line up with it.
        if (state_d == ST_ENTER) begin
            redirect_d    = 1'b1;
            redirect_pc_d = UCODE_BASE;
        end else if (state_d == ST_EXIT) begin
            redirect_d    = 1'b1;
            redirect_pc_d = pc_backup_d;
        end
        in_mm_d = (state_d == ST_ENTER) || (state_d == ST_MATMUL2);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_NORMAL;
            pc_backup   <= 32'h0;
            err         <= 1'b0;
            redirect    <= 1'b0;
            redirect_pc <= 32'h0;
            flush_fd    <= 1'b0;
            busy        <= 1'b0;
            im_sel      <= 1'b0;
            fsm_state   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_backup   <= pc_backup_d;
            err         <= err_d;
            redirect    <= redirect_d;
            redirect_pc <= redirect_pc_d;
            flush_fd    <= redirect_d;
            busy        <= redirect_d;
            im_sel      <= in_mm_d;
            fsm_state   <= in_mm_d;
        end
    end

`ifdef MATMUL_CYCLE_CNT_EN
    logic [CNT_W-1:0] mm_cnt_q;

    // Residency counter: cleared on START, counts MATMUL2 cycles, saturates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mm_cnt_q <= '0;
        end else if (state_d == ST_ENTER) begin
            mm_cnt_q <= '0;
        end else if ((state_q == ST_MATMUL2) && (mm_cnt_q != {CNT_W{1'b1}})) begin
            mm_cnt_q <= mm_cnt_q + CNT_W'(1);
        end
    end

    assign mm_cycles = mm_cnt_q;
`else
    assign mm_cycles = '0;
`endif

endmodule

// File: tb/tb_matmul_mode_ctrl.sv
// Scoreboard bench for matmul_mode_ctrl: the stimulus pushes expected redirects
// (cycle, target, im_sel); a monitor pops and compares whenever redirect is seen.
module tb_matmul_mode_ctrl;

    localparam logic [31:0] UCODE_BASE = 32'h0000_0000;
    localparam int unsigned CNT_W      = 32;
    localparam logic [31:0] I_START    = 32'h0000_007A;
    localparam logic [31:0] I_END      = 32'h0000_707A;
    localparam logic [31:0] I_OTHER    = 32'h0000_307A;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      instr_d;
    logic [31:0]      pc_d;
    logic             valid_d;
    logic             stall_d;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             flush_fd;
    logic             im_sel;
    logic             fsm_state;
    logic [31:0]      pc_backup;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] mm_cycles;

    matmul_mode_ctrl #(.UCODE_BASE(UCODE_BASE), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .instr_d(instr_d), .pc_d(pc_d),
        .valid_d(valid_d), .stall_d(stall_d), .redirect(redirect),
        .redirect_pc(redirect_pc), .flush_fd(flush_fd), .im_sel(im_sel),
        .fsm_state(fsm_state), .pc_backup(pc_backup), .busy(busy),
        .err(err), .mm_cycles(mm_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic        im;
    } exp_t;

    exp_t exp_q[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_err   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_check++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: every redirect must match the oldest expectation.
    always @(negedge clk) begin
        if (redirect === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_check++;
                n_err++;
                $display("FAIL unexpected_redirect: got pc %0h expected none (cycle %0d)", redirect_pc, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("redir_cycle", 64'(cyc), 64'(e.cyc));
                check("redir_pc", 64'(redirect_pc), 64'(e.pc));
                check("redir_im_sel", 64'(im_sel), 64'(e.im));
                check("redir_flush_busy", 64'({flush_fd, busy}), 64'(2'b11));
            end
        end else if (reset === 1'b1 && cyc > 2 && (flush_fd !== 1'b0 || busy !== 1'b0)) begin
            n_check++;
            n_err++;
            $display("FAIL stray_flush_busy: got %0b%0b expected 00 (cycle %0d)", flush_fd, busy, cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        valid_d = 1'b0;
        instr_d = 32'h0000_0013;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present one instruction for one edge; optionally expect a redirect next cycle.
    task automatic issue(logic [31:0] ins, logic [31:0] pc, logic expect_redir,
                         logic [31:0] exp_pc, logic exp_im);
        exp_t e;
        instr_d = ins;
        pc_d    = pc;
        valid_d = 1'b1;
        stall_d = 1'b0;
        if (expect_redir) begin
            e.cyc = cyc + 1;
            e.pc  = exp_pc;
            e.im  = exp_im;
            exp_q.push_back(e);
        end
        tick();
        valid_d = 1'b0;
        instr_d = 32'h0000_0013;
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_outs"}, 64'({redirect, flush_fd, im_sel, fsm_state, busy, err}), 64'(6'b0));
        check({tag, "_pc_backup"}, 64'(pc_backup), 64'(0));
        check({tag, "_redirect_pc"}, 64'(redirect_pc), 64'(0));
        check({tag, "_mm_cycles"}, 64'(mm_cycles), 64'(0));
    endtask

    function automatic logic [63:0] exp_cnt(int n);
`ifdef MATMUL_CYCLE_CNT_EN
        return 64'(n);
`else
        return 64'(0 * n);
`endif
    endfunction

    initial begin
        reset   = 1'b0;
        instr_d = 32'h0000_0013;
        pc_d    = 32'h0;
        valid_d = 1'b0;
        stall_d = 1'b0;
        tick();
        tick();
        check_reset_vals("reset");
        reset = 1'b1;
        idle(1);

        // Basic enter / five MATMUL2 cycles / exit.
        issue(I_START, 32'h40, 1'b1, UCODE_BASE, 1'b1);
        check("enter_pc_backup", 64'(pc_backup), 64'h44);
        check("enter_mode", 64'({fsm_state, im_sel, busy}), 64'(3'b111));
        idle(1);
        check("mm2_mode", 64'({fsm_state, im_sel, busy, redirect}), 64'(4'b1100));
        idle(4);
        issue(I_END, 32'h8, 1'b1, 32'h44, 1'b0);
        check("exit_mode", 64'({fsm_state, im_sel, busy}), 64'(3'b001));
        check("exit_mm_cycles", 64'(mm_cycles), exp_cnt(5));
        idle(1);
        check("normal_after_exit", 64'({fsm_state, im_sel, busy, err}), 64'(4'b0));
        idle(2);
        check("mm_cycles_hold", 64'(mm_cycles), exp_cnt(5));

        // Other funct3 on the custom opcode is ignored.
        issue(I_OTHER, 32'h60, 1'b0, 32'h0, 1'b0);
        check("other_funct3", 64'({fsm_state, err}), 64'(2'b00));

        // START held under stall for three cycles.
        instr_d = I_START;
        pc_d    = 32'h200;
        valid_d = 1'b1;
        stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stalled_no_enter", 64'({fsm_state, busy}), 64'(2'b00));
        end
        issue(I_START, 32'h200, 1'b1, UCODE_BASE, 1'b1);
        check("stall_release_backup", 64'(pc_backup), 64'h204);
        idle(1);
        // Back-to-back END in the first decodable MATMUL2 cycle.
        issue(I_END, 32'h4, 1'b1, 32'h204, 1'b0);
        check("b2b_mm_cycles", 64'(mm_cycles), exp_cnt(1));
        idle(1);

        // Protocol errors: END in NORMAL, then START in MATMUL2.
        issue(I_END, 32'h80, 1'b0, 32'h0, 1'b0);
        check("err_end_in_normal", 64'({err, fsm_state}), 64'(2'b10));
        issue(I_START, 32'h300, 1'b1, UCODE_BASE, 1'b1);
        idle(1);
        issue(I_START, 32'h500, 1'b0, 32'h0, 1'b0);
        check("err_start_in_mm2", 64'({err, fsm_state}), 64'(2'b11));
        check("err_backup_kept", 64'(pc_backup), 64'h304);
        issue(I_END, 32'hC, 1'b1, 32'h304, 1'b0);
        idle(1);
        check("err_sticky", 64'(err), 64'(1));

        // Reset in the middle of MATMUL2.
        issue(I_START, 32'h400, 1'b1, UCODE_BASE, 1'b1);
        idle(2);
        reset = 1'b0;
        tick();
        check_reset_vals("mid_reset");
        reset = 1'b1;
        idle(1);
        issue(I_START, 32'h100, 1'b1, UCODE_BASE, 1'b1);
        check("post_reset_backup", 64'(pc_backup), 64'h104);
        idle(1);
        issue(I_END, 32'h0, 1'b1, 32'h104, 1'b0);
        idle(1);

        // pc_backup wraps at the top of the address space.
        issue(I_START, 32'hFFFF_FFFC, 1'b1, UCODE_BASE, 1'b1);
        check("wrap_backup", 64'(pc_backup), 64'h0);
        idle(2);
        issue(I_END, 32'h10, 1'b1, 32'h0, 1'b0);
        idle(3);

        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_check);
        $finish;
    end

endmodule
